// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA link.
// Samples hsync/vsync/pixel in the pixel-clock domain, recovers line and
// frame timing, qualifies it with a lock FSM and, once locked, issues
// framebuffer write strobes with (x, y) coordinates.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   hsync_in/vsync_in raw sync inputs (polarity set by SYNC_ACTIVE_LOW)
//   pixel_in[2:0]     RGB pixel
//   wr_en/wr_x/wr_y/wr_pixel  framebuffer write port
//   frame_start       one-cycle pulse at vsync trailing edge while locked
//   locked            timing qualified
//   line_len          measured samples per line
//   lines_per_frame   measured lines per frame
module vga_capture #(
  parameter int H_BACK          = 48,
  parameter int H_ACTIVE        = 640,
  parameter int V_BACK          = 33,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  pixel_in,
  output logic        wr_en,
  output logic [9:0]  wr_x,
  output logic [8:0]  wr_y,
  output logic [2:0]  wr_pixel,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  lines_per_frame
);

  localparam logic [10:0] H_LO  = 11'(H_BACK);
  localparam logic [10:0] H_HI  = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_LO  = 10'(V_BACK);
  localparam logic [9:0]  V_HI  = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0]  X_OFF = 10'(H_BACK);
  localparam logic [8:0]  Y_OFF = 9'(V_BACK);

  typedef enum logic [1:0] {UNLOCKED, ARMED, LOCKED} state_t;

  // Sync pipes hold the normalized "sync active" level, so reset (0) is
  // the inactive level regardless of pin polarity. Index 0 = s1.
  logic       h_act, v_act;
  logic [2:0] h_pipe, v_pipe;
  logic [2:0][2:0] p_pipe;

  assign h_act = SYNC_ACTIVE_LOW ? ~hsync_in : hsync_in;
  assign v_act = SYNC_ACTIVE_LOW ? ~vsync_in : vsync_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_pipe <= '0;
      v_pipe <= '0;
      p_pipe <= '0;
    end else begin
      h_pipe <= {h_pipe[1:0], h_act};
      v_pipe <= {v_pipe[1:0], v_act};
      p_pipe <= {p_pipe[1:0], pixel_in};
    end
  end

  logic htrail, vtrail;
  assign htrail = ~h_pipe[1] & h_pipe[2];
  assign vtrail = ~v_pipe[1] & v_pipe[2];

  // Line / frame counters
  logic [10:0] hcnt;
  logic [9:0]  vcnt, line_cnt;
  logic [11:0] period;
  logic        timeout;

  assign period  = {1'b0, hcnt} + 12'd1;
  assign timeout = &hcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt            <= '0;
      vcnt            <= '0;
      line_cnt        <= '0;
      lines_per_frame <= '0;
    end else begin
      if (htrail)        hcnt <= '0;
      else if (!timeout) hcnt <= hcnt + 11'd1;

      if (vtrail)                vcnt <= '0;
      else if (htrail && !(&vcnt)) vcnt <= vcnt + 10'd1;

      // An htrail coincident with vtrail opens the new frame's first line.
      if (vtrail) begin
        lines_per_frame <= line_cnt;
        line_cnt        <= {9'd0, htrail};
      end else if (htrail && !(&line_cnt)) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // Lock FSM
  state_t state;
  logic   have_len;
  logic   mismatch;

  assign mismatch = htrail && (period != {1'b0, line_len});
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      have_len    <= 1'b0;
      line_len    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        UNLOCKED: begin
          if (vtrail) begin
            state    <= ARMED;
            have_len <= 1'b0;
          end
        end
        ARMED: begin
          if (timeout || (have_len && mismatch)) begin
            state <= UNLOCKED;
          end else if (vtrail) begin
            if (have_len && line_len != '0) begin
              state       <= LOCKED;
              frame_start <= 1'b1;
            end else begin
              line_len <= '0;
              have_len <= 1'b0;
            end
          end else if (htrail && !have_len) begin
            line_len <= period[10:0];
            have_len <= 1'b1;
          end
        end
        LOCKED: begin
          if (timeout || mismatch) state <= UNLOCKED;
          if (vtrail) frame_start <= 1'b1;
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

  // Write generation. hcnt lags the pin stream by one more register than
  // s2, so the pixel is taken from s3 to pair each sample with its own
  // coordinates (pin-to-write latency of three clocks).
  logic in_win;
  assign in_win = (hcnt >= H_LO) && (hcnt < H_HI) &&
                  (vcnt >= V_LO) && (vcnt < V_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_pixel <= '0;
    end else if (locked && in_win) begin
      wr_en    <= 1'b1;
      wr_x     <= hcnt[9:0] - X_OFF;
      wr_y     <= vcnt[8:0] - Y_OFF;
      wr_pixel <= p_pipe[2];
    end else begin
      wr_en    <= 1'b0;
      wr_pixel <= '0;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture. Two instances run in parallel on the
// same reduced-size raster: one with active-low syncs, one with inverted
// (active-high) syncs; both are held to the same expected values.
module tb_vga_capture;

  localparam int HB = 4, HA = 8, VB = 2, VA = 3;
  localparam int HS = 3, HF = 2, LL = HS + HB + HA + HF;   // 17 samples/line
  localparam int VS = 1, VF = 1, NL = VS + VB + VA + VF;   // 7 lines/frame

  logic clk = 1'b0;
  logic rst;
  logic hs, vs;            // logical sync level, 1 = asserted
  logic [2:0] pix;

  logic [1:0]       wr_en, frame_start, locked;
  logic [1:0][9:0]  wr_x, lpf;
  logic [1:0][8:0]  wr_y;
  logic [1:0][2:0]  wr_pixel;
  logic [1:0][10:0] line_len;

  vga_capture #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA),
                .SYNC_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .hsync_in(~hs), .vsync_in(~vs), .pixel_in(pix),
    .wr_en(wr_en[0]), .wr_x(wr_x[0]), .wr_y(wr_y[0]), .wr_pixel(wr_pixel[0]),
    .frame_start(frame_start[0]), .locked(locked[0]),
    .line_len(line_len[0]), .lines_per_frame(lpf[0]));

  vga_capture #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA),
                .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .hsync_in(hs), .vsync_in(vs), .pixel_in(pix),
    .wr_en(wr_en[1]), .wr_x(wr_x[1]), .wr_y(wr_y[1]), .wr_pixel(wr_pixel[1]),
    .frame_start(frame_start[1]), .locked(locked[1]),
    .line_len(line_len[1]), .lines_per_frame(lpf[1]));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int edge_n = 0;
  int src_edge = 0, last_ht = 0;
  int wcnt[2], ex[2], ey[2], fs_cnt[2], last_x[2], last_y[2];

  function automatic logic [2:0] pat(input int li, input int pos);
    return 3'(li * 5 + pos);
  endfunction

  function automatic longint outs(input int d);
    return longint'({wr_en[d], wr_x[d], wr_y[d], wr_pixel[d], frame_start[d],
                     locked[d], line_len[d], lpf[d]});
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle write scoreboard: raster order, pixel value, first-pixel latency.
  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      if (frame_start[d]) begin
        fs_cnt[d]++; wcnt[d] = 0; ex[d] = 0; ey[d] = 0;
      end
      if (wr_en[d]) begin
        chk($sformatf("d%0d_wr_xy", d), wr_y[d] * 1024 + wr_x[d], ey[d] * 1024 + ex[d]);
        chk($sformatf("d%0d_wr_pixel", d), wr_pixel[d], pat(ey[d] + VB + VS, ex[d] + HB + HS));
        if (ex[d] == 0 && ey[d] == 0) chk($sformatf("d%0d_latency", d), edge_n - src_edge, 3);
        last_x[d] = wr_x[d]; last_y[d] = wr_y[d];
        wcnt[d]++;
        ex[d]++;
        if (ex[d] == HA) begin ex[d] = 0; ey[d]++; end
        if (ey[d] == VA) ey[d] = 0;
      end
    end
  endtask

  task automatic step(input logic h, input logic v, input logic [2:0] p);
    hs = h; vs = v; pix = p;
    @(posedge clk);
    edge_n++;
    #1;
    monitor();
  endtask

  // Line li, positions p0..p1. hsync asserted at positions 0..HS-1; vsync
  // changes at position HS so its trailing edge coincides with an htrail.
  task automatic drive_line(input int li, input int p0, input int p1);
    for (int pos = p0; pos <= p1; pos++) begin
      bit vv;
      vv = (li < VS) ? (li > 0 || pos >= HS) : (li == VS && pos < HS);
      if (li == VS + VB && pos == HS + HB) src_edge = edge_n + 1;
      if (pos == HS) last_ht = edge_n + 1;
      step(pos < HS, vv, pat(li, pos));
    end
  endtask

  task automatic drive_frame(input int short_li);
    for (int li = 0; li < NL; li++)
      drive_line(li, 0, (li == short_li) ? LL - 2 : LL - 1);
  endtask

  task automatic chk_both(input string tag, input int which, input longint exp);
    for (int d = 0; d < 2; d++) begin
      case (which)
        0: chk($sformatf("d%0d_%s", d, tag), locked[d], exp);
        1: chk($sformatf("d%0d_%s", d, tag), line_len[d], exp);
        2: chk($sformatf("d%0d_%s", d, tag), lpf[d], exp);
        3: chk($sformatf("d%0d_%s", d, tag), wcnt[d], exp);
        4: chk($sformatf("d%0d_%s", d, tag), fs_cnt[d], exp);
        5: chk($sformatf("d%0d_%s", d, tag), last_y[d] * 1024 + last_x[d], exp);
        6: chk($sformatf("d%0d_%s", d, tag), frame_start[d], exp);
        7: chk($sformatf("d%0d_%s", d, tag), wr_en[d], exp);
        default: chk($sformatf("d%0d_%s", d, tag), outs(d), exp);
      endcase
    end
  endtask

  initial begin
    int w0;
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0; ex[d] = 0; ey[d] = 0; fs_cnt[d] = 0; last_x[d] = 0; last_y[d] = 0;
    end
    hs = 1'b0; vs = 1'b0; pix = '0; rst = 1'b1;

    // Reset with toggling inputs
    repeat (5) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    chk_both("reset_outs", 8, 0);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 3'd0);

    // Frame 1: first vtrail arms, line length measured
    drive_frame(-1);
    chk_both("f1_locked", 0, 0);
    chk_both("f1_line_len", 1, LL);
    chk_both("f1_lpf", 2, 1);

    // Frame 2: second vtrail locks; check exact lock latency
    drive_line(0, 0, LL - 1);
    drive_line(VS, 0, HS + 1);
    chk_both("lock_early", 0, 0);
    drive_line(VS, HS + 2, HS + 2);
    chk_both("lock_rise", 0, 1);
    chk_both("fs_pulse", 6, 1);
    drive_line(VS, HS + 3, LL - 1);
    chk_both("fs_single", 6, 0);
    for (int li = VS + 1; li < NL; li++) drive_line(li, 0, LL - 1);
    chk_both("f2_lpf", 2, NL);
    chk_both("f2_writes", 3, HA * VA);

    // Frame 3: full locked frame
    drive_frame(-1);
    chk_both("f3_writes", 3, HA * VA);
    chk_both("f3_last_xy", 5, (VA - 1) * 1024 + (HA - 1));
    chk_both("f3_fs_cnt", 4, 2);
    chk_both("f3_locked", 0, 1);
    chk_both("f3_line_len", 1, LL);

    // Frame 4: line 4 one sample short; lock lost at the following htrail
    for (int li = 0; li < 4; li++) drive_line(li, 0, LL - 1);
    drive_line(4, 0, LL - 2);
    drive_line(5, 0, HS + 1);
    chk_both("glitch_pre", 0, 1);
    drive_line(5, HS + 2, HS + 2);
    chk_both("glitch_drop", 0, 0);
    drive_line(5, HS + 3, LL - 1);
    drive_line(6, 0, LL - 1);
    chk_both("glitch_writes", 3, 2 * HA);

    // Relock two vtrails later
    drive_frame(-1);
    chk_both("f5_locked", 0, 0);
    drive_frame(-1);
    chk_both("f6_locked", 0, 1);
    chk_both("f6_writes", 3, HA * VA);
    chk_both("f6_fs_cnt", 4, 4);

    // hsync stuck inactive: lock lost when hcnt saturates at 2047
    w0 = wcnt[0];
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 1'b0, 3'($urandom_range(0, 7)));
      if (edge_n == last_ht + 2049) chk_both("timeout_pre", 0, 1);
      if (edge_n == last_ht + 2050) chk_both("timeout_drop", 0, 0);
    end
    chk_both("stuck_locked", 0, 0);
    chk_both("stuck_writes", 3, w0);

    // Relock, then reset in the middle of an active line
    drive_frame(-1);
    drive_frame(-1);
    chk_both("f8_locked", 0, 1);
    for (int li = 0; li < 4; li++) drive_line(li, 0, LL - 1);
    drive_line(4, 0, HS + HB + 5);
    chk_both("pre_rst_wr_en", 7, 1);
    #2 rst = 1'b1;
    #1;
    chk_both("mid_rst_outs", 8, 0);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 3'd0);

    drive_frame(-1);
    chk_both("post_rst_f1_locked", 0, 0);
    drive_frame(-1);
    chk_both("post_rst_locked", 0, 1);
    chk_both("post_rst_writes", 3, HA * VA);
    chk_both("post_rst_last_xy", 5, (VA - 1) * 1024 + (HA - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
